fir_sample_tx: RTL

- Transmit end of the filter sample interface: drives `input_sig` and `ready` into the FIR socket.
- Buffers samples pushed by a host or loader in a small FIFO.
- Releases one sample every DIV clocks with a one-cycle `ready` strobe.
- Replaces file-driven sample pacing with synthesizable RTL, so the filter can run on hardware from a sample stream.

---
 rtl/fir_sample_tx_pkg.sv | 17 +
 rtl/fir_sample_fifo.sv | 64 ++++++
 rtl/fir_sample_tx.sv | 117 +++++++++++
 3 files changed

// File: rtl/fir_sample_tx_pkg.sv
// Shared types and helpers for the FIR sample transmitter.
// The FIR_SAMPLE_TX_ZERO_FILL_EN build option is consumed by fir_sample_tx.
package fir_sample_tx_pkg;

   localparam int unsigned DEF_WIDTH = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous FIFO holding samples waiting to be paced out to the filter.
// Writes while full and reads while empty are ignored.
module fir_sample_fifo
   import fir_sample_tx_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          push,
   input  logic                          pop,
   output logic [WIDTH-1:0]              pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = level_width(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   always_comb begin
      full     = (level_q == FULL_LVL);
      empty    = (level_q == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (!do_push && do_pop) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign level    = level_q;

endmodule

// File: rtl/fir_sample_tx.sv
// Paces buffered samples out to the FIR socket, one ready strobe every DIV clocks.
// Define FIR_SAMPLE_TX_ZERO_FILL_EN to emit zero samples on empty ticks instead of re-priming.
module fir_sample_tx
   import fir_sample_tx_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned DIV   = 128,
   parameter int unsigned PRIME = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic                          enable,
   input  logic                          clr_underflow,
   output logic [WIDTH-1:0]              input_sig,
   output logic                          ready,
   output logic                          underflow,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int unsigned LW = level_width(DEPTH);
   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic             ready_q, ready_d;
   logic             unf_q, unf_d;
   logic             tick;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [WIDTH-1:0] fifo_head;
   logic [LW-1:0]    fifo_level;

   fir_sample_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_data (wr_data),
      .push      (wr_valid),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // The counter defaults to zero so every way into RUN starts a fresh period.
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      sig_d    = sig_q;
      ready_d  = 1'b0;
      unf_d    = unf_q;
      fifo_pop = 1'b0;
      tick     = (cnt_q == CNT_LAST);
      if (clr_underflow) unf_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_PRIME;
         end
         ST_PRIME: begin
            if (!enable)                      state_d = ST_IDLE;
            else if (fifo_level >= PRIME_LVL) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (!tick) begin
               cnt_d = cnt_q + 1'b1;
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sig_d    = fifo_head;
               ready_d  = 1'b1;
            end else begin
               unf_d = 1'b1;
`ifdef FIR_SAMPLE_TX_ZERO_FILL_EN
               sig_d   = '0;
               ready_d = 1'b1;
`else
               state_d = ST_PRIME;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sig_q   <= '0;
         ready_q <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sig_q   <= sig_d;
         ready_q <= ready_d;
         unf_q   <= unf_d;
      end
   end

   assign wr_ready  = !fifo_full;
   assign input_sig = sig_q;
   assign ready     = ready_q;
   assign underflow = unf_q;
   assign level     = fifo_level;

endmodule
